i2c_master_byte: RTL and testbench
==================================

# i2c_master_byte

Single-byte I2C master controller that generates START, a 7-bit address phase, one data byte and STOP on an open-drain SCL/SDA pair. It sits directly upstream of the I2C slave devices on the bus: it drives `scl` and shares `sda` with them. It is the bus driver for the communication-protocol testbenches and for small register-access use. It latches a command on a one-cycle `start` pulse, checks the slave ACKs, and reports completion with a `done` pulse.

## Interface
- `CLK_DIV`, 250: system clocks per quarter SCL period; 250 gives 100 kHz from 100 MHz; minimum legal value 2.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: command strobe; sampled only in IDLE.
- `rw` input 1: 0 = write `wdata`, 1 = read one byte.
- `addr` input 7: target slave address.
- `wdata` input 8: byte to write.
- `scl` output 1: bus clock; driven 1 = released (pulled high), 0 = low.
- `sda` inout 1: open-drain; driven `1'b0` or `1'bz` only, never `1'b1`.
- `busy` output 1: high from the accepted `start` until `done`.
- `done` output 1: one-cycle pulse at end of frame.
- `ack_err` output 1: set if any expected slave ACK read high.
- `rd_data` output 8: last received byte.

## Operation
- Reset values:
  - `scl` = 1, `sda` released.
  - `busy`, `done`, `ack_err` = 0.
  - `rd_data` = 0x00.
  - state IDLE, divider and bit counter cleared.
- Command acceptance: `start` high in IDLE latches `addr`, `rw`, `wdata`, sets `busy`, clears `ack_err`. `start` while busy is ignored.
- Each bus bit is four quarter phases, Q0..Q3, each `CLK_DIV` clocks:
  - Q0: `scl` low, SDA updated.
  - Q1: `scl` high.
  - Q2: `scl` high, SDA sampled at phase start.
  - Q3: `scl` low.
- States:
  - IDLE → START (on `start`).
  - START: SDA falls while SCL high, then SCL low → ADDR.
  - ADDR: 8 bits, {addr, rw}, MSB first → ADDR_ACK.
  - ADDR_ACK: SDA released, sample. Low → WDATA if rw=0, RDATA if rw=1. High → set `ack_err`, go to STOP.
  - WDATA: 8 bits MSB first → WDATA_ACK. That sample high sets `ack_err`. Either way → STOP.
  - RDATA: SDA released, shift in 8 bits MSB first → RDATA_NACK.
  - RDATA_NACK: master leaves SDA released (NACK); `rd_data` updated on entry → STOP.
  - STOP: SCL low with SDA low, then SCL high, then SDA released → IDLE with `done` pulse and `busy` low in the same cycle.
- No clock stretching, no arbitration, no repeated START.
- Reset mid-frame aborts immediately: SCL and SDA released, no STOP generated.

## Timing
- Frame length: 20 bit-times (START + 9 + 9 + STOP) = 80 × `CLK_DIV` clocks.
- `done` asserts 80×`CLK_DIV` + 1 clocks after the `start` cycle.
- `busy` rises the cycle after `start` is sampled.
- START setup: SDA low at least `CLK_DIV` clocks before SCL falls.
- STOP setup: SCL high at least `CLK_DIV` clocks before SDA rises.
- SDA changes only in Q0, while SCL is low, except at START and STOP.
- `ack_err` holds until the next accepted `start`.
- `rd_data` holds until the next completed read.

## Configuration
- `I2C_MASTER_READ_EN`
  - Defined: `rw` honoured; RDATA/RDATA_NACK states and `rd_data` register exist.
  - Undefined: `rw` ignored and transmitted as 0; RDATA/RDATA_NACK removed; `rd_data` tied to 0x00.

## Structure
- Package `i2c_pkg`: state enum, quarter-phase constants Q0..Q3, `I2C_ADDR_W` = 7, `I2C_DATA_W` = 8.
- Sub-module `i2c_quarter_tick`: counter of width $clog2(`CLK_DIV`) emitting a one-cycle tick every `CLK_DIV` clocks. Cleared by `rst` and while IDLE.
- Bit counter, shift register, SDA/SCL drive and FSM live in the top module.

## Test plan
- Write with ACK: `CLK_DIV`=4, pullups on bus, slave at 0x42 ACKs. `start`, addr=0x42, rw=0, wdata=0xA5 → SDA bits 0x84 then 0xA5, `ack_err`=0, `done` at cycle 321, slave holds 0xA5.
- Address NACK: no slave at 0x13; write → `ack_err`=1, STOP immediately after ADDR_ACK, `done` after 11 bit-times.
- Read (macro defined): slave returns 0x3C → address byte 0x85 on bus, master NACKs, `rd_data`=0x3C, `ack_err`=0.
- `start` re-pulsed while `busy` → ignored; exactly one frame and one `done` pulse.
- `rst` asserted mid-ADDR → same cycle `scl`=1, `sda`=z, `busy`=0. A following `start` runs a clean frame.
- Protocol monitor throughout: SDA never changes while SCL is high except at START and STOP; `sda` never driven to 1.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
// The read states exist only when I2C_MASTER_READ_EN is defined.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_STOP
`ifdef I2C_MASTER_READ_EN
        ,
        ST_RDATA,
        ST_RDATA_NACK
`endif
    } i2c_state_e;

    // Bus levels for a given state/quarter: {scl, sda_low}.
    function automatic logic [1:0] bus_drive(i2c_state_e st, logic [1:0] q, logic tx_bit);
        logic scl_hi;
        scl_hi = (q == Q1) || (q == Q2);
        case (st)
            ST_IDLE:          return 2'b10;
            ST_START:         return {q != Q3, q != Q0};
            ST_STOP:          return {q != Q0, q != Q3};
            ST_ADDR, ST_WDATA: return {scl_hi, ~tx_bit};
            default:          return {scl_hi, 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-phase timebase: one-cycle tick every CLK_DIV clocks while enabled.
// Held at zero while disabled so the first quarter of a frame is full length.
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, STOP.
// Define I2C_MASTER_READ_EN to honour rw and enable the read path.
module i2c_master_byte
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       scl,
    inout  wire        sda,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rd_data
);

    i2c_state_e state, nxt_state;
    logic [1:0] quarter, nxt_q;
    logic [2:0] bit_idx, nxt_bit;
    logic       tick;
    logic       sda_low;
    logic       sda_smp;
    logic [6:0] addr_l;
    logic [7:0] wdata_l;
    logic       rw_bit;
    logic [7:0] tx_byte;
    logic       tx_bit;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state != ST_IDLE),
        .tick (tick)
    );

`ifdef I2C_MASTER_READ_EN
    logic       rw_l;
    logic [7:0] rx_sh;

    assign rw_bit = rw_l;

    always_ff @(posedge clk) begin
        if (state == ST_RDATA && tick && quarter == Q1) begin
            rx_sh <= {rx_sh[6:0], sda};
        end
    end
`else
    logic unused_rw;

    assign unused_rw = rw;
    assign rw_bit    = 1'b0;
    assign rd_data   = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            addr_l  <= addr;
            wdata_l <= wdata;
`ifdef I2C_MASTER_READ_EN
            rw_l    <= rw;
`endif
        end
    end

    // Bit to present on SDA in the quarter being entered.
    assign tx_byte = (nxt_state == ST_ADDR) ? {addr_l, rw_bit} : wdata_l;
    assign tx_bit  = tx_byte[nxt_bit];

    always_comb begin
        nxt_state = state;
        nxt_q     = quarter;
        nxt_bit   = bit_idx;
        if (state == ST_IDLE) begin
            if (start) begin
                nxt_state = ST_START;
                nxt_q     = Q0;
            end
        end else if (tick) begin
            nxt_q = quarter + 2'd1;
            if (quarter == Q3) begin
                case (state)
                    ST_START: begin
                        nxt_state = ST_ADDR;
                        nxt_bit   = 3'd7;
                    end
                    ST_ADDR: begin
                        if (bit_idx == 3'd0) nxt_state = ST_ADDR_ACK;
                        else                 nxt_bit   = bit_idx - 3'd1;
                    end
                    ST_ADDR_ACK: begin
                        nxt_bit = 3'd7;
                        if (sda_smp)     nxt_state = ST_STOP;
`ifdef I2C_MASTER_READ_EN
                        else if (rw_l)   nxt_state = ST_RDATA;
`endif
                        else             nxt_state = ST_WDATA;
                    end
                    ST_WDATA: begin
                        if (bit_idx == 3'd0) nxt_state = ST_WDATA_ACK;
                        else                 nxt_bit   = bit_idx - 3'd1;
                    end
                    ST_WDATA_ACK: nxt_state = ST_STOP;
`ifdef I2C_MASTER_READ_EN
                    ST_RDATA: begin
                        if (bit_idx == 3'd0) nxt_state = ST_RDATA_NACK;
                        else                 nxt_bit   = bit_idx - 3'd1;
                    end
                    ST_RDATA_NACK: nxt_state = ST_STOP;
`endif
                    default: nxt_state = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            quarter <= Q0;
            bit_idx <= 3'd0;
            scl     <= 1'b1;
            sda_low <= 1'b0;
            sda_smp <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
`ifdef I2C_MASTER_READ_EN
            rd_data <= 8'h00;
`endif
        end else begin
            done    <= 1'b0;
            state   <= nxt_state;
            quarter <= nxt_q;
            bit_idx <= nxt_bit;
            {scl, sda_low} <= bus_drive(nxt_state, nxt_q, tx_bit);
            if (state == ST_IDLE && start) begin
                busy    <= 1'b1;
                ack_err <= 1'b0;
            end
            // Sample on entry to Q2, after SCL has been high for a full quarter.
            if (tick && quarter == Q1) begin
                sda_smp <= sda;
            end
            if (tick && quarter == Q3) begin
                if ((state == ST_ADDR_ACK || state == ST_WDATA_ACK) && sda_smp) begin
                    ack_err <= 1'b1;
                end
                if (state == ST_STOP) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
`ifdef I2C_MASTER_READ_EN
                if (state == ST_RDATA && bit_idx == 3'd0) begin
                    rd_data <= rx_sh;
                end
`endif
            end
        end
    end

    assign sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Scoreboard bench for i2c_master_byte with a behavioural slave at 0x42 on a pulled-up bus.
module tb_i2c_master_byte;

    localparam int D = 4;
    localparam logic [6:0] SLAVE_ADDR = 7'h42;
`ifdef I2C_MASTER_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] addr_byte;
        logic       data_seen;
        logic [7:0] data_byte;
        logic       ack_err;
        logic [7:0] rd_data;
        int         latency;
        int         start_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'h00;
    logic [7:0] wdata = 8'h00;
    logic       scl, busy, done, ack_err;
    logic [7:0] rd_data;
    wire        sda;
    logic       slave_low;

    assign sda = slave_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_master_byte #(.CLK_DIV(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rw      (rw),
        .addr    (addr),
        .wdata   (wdata),
        .scl     (scl),
        .sda     (sda),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .rd_data (rd_data)
    );

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural slave: decodes the bus from edges and answers address 0x42.
    logic       slave_nack_data = 1'b0;
    logic [7:0] slave_rd_byte = 8'h00;
    logic       prev_scl, prev_sda, in_frame, matched, rd_mode, data_seen;
    logic [7:0] sh, addr_obs, data_obs;
    int         bitn, byte_no, nstart, nstop;

    always @(negedge clk) begin
        if (rst) begin
            prev_scl  <= 1'b1;
            prev_sda  <= 1'b1;
            in_frame  <= 1'b0;
            slave_low <= 1'b0;
            nstart    <= 0;
            nstop     <= 0;
            data_seen <= 1'b0;
            matched   <= 1'b0;
            rd_mode   <= 1'b0;
            bitn      <= 0;
            byte_no   <= 0;
        end else begin
            prev_scl <= scl;
            prev_sda <= sda;
            if (prev_scl && scl && prev_sda && !sda) begin
                in_frame  <= 1'b1;
                bitn      <= 0;
                byte_no   <= 0;
                data_seen <= 1'b0;
                slave_low <= 1'b0;
                nstart    <= nstart + 1;
            end else if (prev_scl && scl && !prev_sda && sda) begin
                in_frame  <= 1'b0;
                slave_low <= 1'b0;
                nstop     <= nstop + 1;
            end else if (in_frame && !prev_scl && scl) begin
                if (bitn < 8) sh <= {sh[6:0], sda};
                bitn <= bitn + 1;
            end else if (in_frame && prev_scl && !scl) begin
                if (bitn == 8) begin
                    if (byte_no == 0) begin
                        addr_obs  <= sh;
                        matched   <= (sh[7:1] == SLAVE_ADDR);
                        rd_mode   <= sh[0];
                        slave_low <= (sh[7:1] == SLAVE_ADDR);
                    end else if (byte_no == 1) begin
                        data_seen <= 1'b1;
                        data_obs  <= sh;
                        slave_low <= matched && !rd_mode && !slave_nack_data;
                    end
                end else if (bitn == 9) begin
                    bitn      <= 0;
                    byte_no   <= byte_no + 1;
                    slave_low <= (byte_no == 0 && rd_mode && matched) ? ~slave_rd_byte[7] : 1'b0;
                end else if (byte_no == 1 && rd_mode && matched) begin
                    slave_low <= ~slave_rd_byte[7-bitn];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    int base_start = 0;
    int base_stop = 0;

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                base_start = 0;
                base_stop  = 0;
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_err", ack_err, e.ack_err);
                    chk("rd_data", rd_data, e.rd_data);
                    chk("done_latency", cyc - e.start_cyc, e.latency);
                    chk("busy_at_done", busy, 0);
                    chk("addr_byte_on_bus", addr_obs, e.addr_byte);
                    chk("data_byte_present", data_seen, e.data_seen);
                    if (e.data_seen) chk("data_byte_on_bus", data_obs, e.data_byte);
                    chk("start_conditions", nstart - base_start, 1);
                    chk("stop_conditions", nstop - base_stop, 1);
                end
                base_start = nstart;
                base_stop  = nstop;
            end
        end
    endtask

    logic [7:0] last_rd = 8'h00;
    logic       hold_ack = 1'b0;

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] w,
                           input logic nack, input logic [7:0] rdb, input bit repulse);
        exp_t e;
        logic rw_eff;
        int   bits;
        bit   got;
        chk("busy_idle", busy, 0);
        chk("ack_err_hold", ack_err, hold_ack);
        chk("rd_data_hold", rd_data, last_rd);
        rw_eff = READ_EN ? r : 1'b0;
        e.addr_byte = {a, rw_eff};
        if (a != SLAVE_ADDR) begin
            e.ack_err = 1'b1; e.data_seen = 1'b0; e.data_byte = 8'h00; bits = 11;
        end else if (rw_eff) begin
            e.ack_err = 1'b0; e.data_seen = 1'b1; e.data_byte = rdb; bits = 20;
            last_rd = rdb;
        end else begin
            e.ack_err = nack; e.data_seen = 1'b1; e.data_byte = w; bits = 20;
        end
        e.rd_data = last_rd;
        e.latency = bits * 4 * D + 1;
        hold_ack  = e.ack_err;
        @(negedge clk);
        slave_nack_data = nack;
        slave_rd_byte   = rdb;
        addr  = a;
        rw    = r;
        wdata = w;
        start = 1'b1;
        e.start_cyc = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        if (repulse) begin
            repeat (30) @(negedge clk);
            addr  = ~a;
            wdata = ~w;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < e.latency + 20; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_in_time", got, 1);
        if (!got) begin
            exp_q.delete();
            rst = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            last_rd  = 8'h00;
            hold_ack = 1'b0;
        end
        if (repulse) repeat (90 * D) @(negedge clk);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fork
            monitor_loop();
        join_none
        repeat (3) @(negedge clk);
        chk("reset_scl", scl, 1);
        chk("reset_sda", sda, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ack_err", ack_err, 0);
        chk("reset_rd_data", rd_data, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_txn(7'h42, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0);
        run_txn(7'h13, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b0);
        run_txn(7'h42, 1'b1, 8'h00, 1'b0, 8'h3C, 1'b0);
        run_txn(7'h42, 1'b0, 8'h77, 1'b1, 8'h00, 1'b0);
        run_txn(7'h42, 1'b0, 8'h11, 1'b0, 8'h00, 1'b1);

        // Abort mid-address: the bus must be released at once.
        @(negedge clk);
        addr  = 7'h42;
        rw    = 1'b0;
        wdata = 8'hC3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4 * D + 10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_scl", scl, 1);
        chk("abort_sda", sda, 1);
        chk("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("abort_ack_err", ack_err, 0);
        chk("abort_rd_data", rd_data, 0);
        rst = 1'b0;
        last_rd  = 8'h00;
        hold_ack = 1'b0;
        repeat (3) @(negedge clk);

        for (int n = 0; n < 10; n++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 2) != 0) ? SLAVE_ADDR : 7'($urandom);
            run_txn(a, 1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
                    8'($urandom), 1'b0);
        end

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
